// File: rtl/sb_tx_serializer_if.sv
// ----------------------------------------------------------------------------
// sb_tx_serializer_if
//
// Packet-post handshake and serial-lane bundle between the sideband control
// FSM (master) and the sideband TX serializer (slave). Signal names keep the
// serializer's point of view, so i_* are driven by the FSM and o_* by the
// serializer.
//
// Signals:
//   i_packet_enable  packet-post strobe, qualified by o_packet_ready
//   i_header         framed header word
//   i_data           framed data word (ignored when i_has_data = 0)
//   i_has_data       packet is header + data when 1, header only when 0
//   o_packet_ready   holding slot is free
//   o_tx_data        serial TX bit
//   o_tx_clk_en      forwarded sideband clock gate, high only on data UI
//   o_packet_sent    one-cycle pulse in the final gap UI of a packet
//   o_busy           serializer active or a packet is held
// ----------------------------------------------------------------------------
interface sb_tx_serializer_if #(
  parameter int WORD_W = 64
) ();

  logic              i_packet_enable;
  logic [WORD_W-1:0] i_header;
  logic [WORD_W-1:0] i_data;
  logic              i_has_data;
  logic              o_packet_ready;
  logic              o_tx_data;
  logic              o_tx_clk_en;
  logic              o_packet_sent;
  logic              o_busy;

  // Sideband control FSM side.
  modport master (
    output i_packet_enable,
    output i_header,
    output i_data,
    output i_has_data,
    input  o_packet_ready,
    input  o_tx_data,
    input  o_tx_clk_en,
    input  o_packet_sent,
    input  o_busy
  );

  // Serializer side.
  modport slave (
    input  i_packet_enable,
    input  i_header,
    input  i_data,
    input  i_has_data,
    output o_packet_ready,
    output o_tx_data,
    output o_tx_clk_en,
    output o_packet_sent,
    output o_busy
  );

endinterface : sb_tx_serializer_if

// File: rtl/sb_tx_serializer.sv
// ----------------------------------------------------------------------------
// sb_tx_serializer
//
// Sideband transmit serializer. Accepts a framed header word and an optional
// data word from the sideband control FSM, shifts them out LSB-first on the
// single-bit TX lane with a matching clock enable, then holds the lane low for
// exactly GAP_UI UI. A one-deep holding register lets the FSM post the next
// packet while the current one is on the wire; a held packet starts in the UI
// right after the previous packet's o_packet_sent pulse.
//
// Parameters:
//   WORD_W  bits per header or data word (counter is 7 bits, so <= 128)
//   GAP_UI  idle-low UI after each packet (2 .. 128)
//
// Ports:
//   i_clk    sideband serial clock, one UI per cycle
//   i_rst_n  asynchronous active-low reset
//   sb       slave side of sb_tx_serializer_if (handshake + serial lane)
//
// Timing: state, shift registers and the TX outputs are all registered from
// the same next-state logic, so the cycle after an accepting edge already
// carries header bit 0. o_packet_ready and o_busy decode registers only.
// ----------------------------------------------------------------------------
module sb_tx_serializer #(
  parameter int WORD_W = 64,
  parameter int GAP_UI = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  sb_tx_serializer_if.slave sb
);

  localparam int                CNT_W     = 7;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  WORD_LAST = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_UI - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHIFT_HDR  = 2'd1,
    SHIFT_DATA = 2'd2,
    GAP        = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t             state_q,         state_d;
  logic [CNT_W-1:0]   cnt_q,           cnt_d;
  logic [WORD_W-1:0]  hdr_sr_q,        hdr_sr_d;
  logic [WORD_W-1:0]  dat_sr_q,        dat_sr_d;
  logic               has_data_q,      has_data_d;
  logic               hold_valid_q,    hold_valid_d;
  logic [WORD_W-1:0]  hold_hdr_q,      hold_hdr_d;
  logic [WORD_W-1:0]  hold_dat_q,      hold_dat_d;
  logic               hold_has_data_q, hold_has_data_d;
  logic               tx_data_q,       tx_data_d;
  logic               tx_clk_en_q,     tx_clk_en_d;
  logic               packet_sent_q,   packet_sent_d;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic accept;        // packet taken on this edge
  logic last_gap;      // current UI is the final idle-low UI
  logic direct_start;  // accepted packet bypasses the holding register

  assign accept       = sb.i_packet_enable & ~hold_valid_q;
  assign last_gap     = (state_q == GAP) && (cnt_q == GAP_LAST);
  assign direct_start = accept && ((state_q == IDLE) || last_gap);

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d         = state_q;
    cnt_d           = cnt_q + CNT_ONE;
    hdr_sr_d        = hdr_sr_q;
    dat_sr_d        = dat_sr_q;
    has_data_d      = has_data_q;
    hold_valid_d    = hold_valid_q;
    hold_hdr_d      = hold_hdr_q;
    hold_dat_d      = hold_dat_q;
    hold_has_data_d = hold_has_data_q;

    // A post that cannot start on this edge parks in the holding slot. Ready
    // is low whenever the slot is full, so this never overwrites a held packet.
    if (accept && !direct_start) begin
      hold_valid_d    = 1'b1;
      hold_hdr_d      = sb.i_header;
      hold_dat_d      = sb.i_data;
      hold_has_data_d = sb.i_has_data;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d    = SHIFT_HDR;
          hdr_sr_d   = sb.i_header;
          dat_sr_d   = sb.i_data;
          has_data_d = sb.i_has_data;
        end
      end

      SHIFT_HDR: begin
        hdr_sr_d = hdr_sr_q >> 1;
        if (cnt_q == WORD_LAST) begin
          cnt_d   = '0;
          state_d = has_data_q ? SHIFT_DATA : GAP;
        end
      end

      SHIFT_DATA: begin
        dat_sr_d = dat_sr_q >> 1;
        if (cnt_q == WORD_LAST) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end

      GAP: begin
        if (last_gap) begin
          cnt_d = '0;
          // The held packet always wins; a same-cycle post cannot coexist
          // with it because ready is low while the slot is full.
          if (hold_valid_q) begin
            state_d      = SHIFT_HDR;
            hdr_sr_d     = hold_hdr_q;
            dat_sr_d     = hold_dat_q;
            has_data_d   = hold_has_data_q;
            hold_valid_d = 1'b0;
          end else if (accept) begin
            state_d    = SHIFT_HDR;
            hdr_sr_d   = sb.i_header;
            dat_sr_d   = sb.i_data;
            has_data_d = sb.i_has_data;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered copies of what the next state puts on the wire,
    // which keeps them glitch-free and aligned with the state register.
    tx_clk_en_d   = (state_d == SHIFT_HDR) || (state_d == SHIFT_DATA);
    tx_data_d     = (state_d == SHIFT_HDR)  ? hdr_sr_d[0] :
                    (state_d == SHIFT_DATA) ? dat_sr_d[0] : 1'b0;
    packet_sent_d = (state_d == GAP) && (cnt_d == GAP_LAST);
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: shift and holding registers are reset along with the control
      // state so a mid-packet reset leaves no stale payload behind.
      state_q         <= IDLE;
      cnt_q           <= '0;
      hdr_sr_q        <= '0;
      dat_sr_q        <= '0;
      has_data_q      <= 1'b0;
      hold_valid_q    <= 1'b0;
      hold_hdr_q      <= '0;
      hold_dat_q      <= '0;
      hold_has_data_q <= 1'b0;
      tx_data_q       <= 1'b0;
      tx_clk_en_q     <= 1'b0;
      packet_sent_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      hdr_sr_q        <= hdr_sr_d;
      dat_sr_q        <= dat_sr_d;
      has_data_q      <= has_data_d;
      hold_valid_q    <= hold_valid_d;
      hold_hdr_q      <= hold_hdr_d;
      hold_dat_q      <= hold_dat_d;
      hold_has_data_q <= hold_has_data_d;
      tx_data_q       <= tx_data_d;
      tx_clk_en_q     <= tx_clk_en_d;
      packet_sent_q   <= packet_sent_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign sb.o_tx_data      = tx_data_q;
  assign sb.o_tx_clk_en    = tx_clk_en_q;
  assign sb.o_packet_sent  = packet_sent_q;
  assign sb.o_packet_ready = ~hold_valid_q;
  assign sb.o_busy         = (state_q != IDLE) || hold_valid_q;

endmodule : sb_tx_serializer

// File: tb/tb_sb_tx_serializer.sv
// ----------------------------------------------------------------------------
// tb_sb_tx_serializer
//
// Directed bench for sb_tx_serializer. Two instances share clock and reset:
// u_dut with GAP_UI = 32 and u_dut4 with GAP_UI = 4. Every accepted packet
// pushes its expected wire bits (header LSB-first, then data) into a per-
// instance queue; a monitor pops one bit per clk_en UI and also checks that
// the lane is low whenever clk_en is low. Directed steps check handshake and
// pulse timing relative to the accepting edge E0, where cycle E0+k is the
// k-th clock period after that edge.
// ----------------------------------------------------------------------------
module tb_sb_tx_serializer;

  localparam int WORD_W = 64;
  localparam int GAP_A  = 32;
  localparam int GAP_B  = 4;

  logic clk;
  logic rst_n;
  int   cyc;

  int   n_cmp;
  int   n_err;

  sb_tx_serializer_if #(.WORD_W(WORD_W)) sb  ();
  sb_tx_serializer_if #(.WORD_W(WORD_W)) sb4 ();

  sb_tx_serializer #(.WORD_W(WORD_W), .GAP_UI(GAP_A)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .sb      (sb)
  );

  sb_tx_serializer #(.WORD_W(WORD_W), .GAP_UI(GAP_B)) u_dut4 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .sb      (sb4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboards and monitor state.
  bit exp_q[$];
  bit exp4_q[$];
  int rise4_q[$];
  int low_run;
  int last_gap;
  bit prev_en;
  bit prev_en4;
  int pulse_cnt4;
  int n_post4;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Main-instance monitor: wire bits against the scoreboard, idle-low lane,
  // and the length of the most recent low run before a burst.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.o_tx_clk_en) begin
        if (!prev_en) last_gap = low_run;
        low_run = 0;
        if (exp_q.size() == 0) check("unexpected_clk_en", sb.o_tx_clk_en, 1'b0);
        else check("tx_bit", sb.o_tx_data, exp_q.pop_front());
      end else begin
        low_run++;
        check("idle_low", sb.o_tx_data, 1'b0);
      end
      prev_en = sb.o_tx_clk_en;
    end else begin
      prev_en = 1'b0;
      low_run = 0;
    end
  end

  // GAP_UI = 4 instance monitor: wire bits, burst start cycles, pulse count.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb4.o_tx_clk_en) begin
        if (!prev_en4) rise4_q.push_back(cyc);
        if (exp4_q.size() == 0) check("unexpected_clk_en4", sb4.o_tx_clk_en, 1'b0);
        else check("tx_bit4", sb4.o_tx_data, exp4_q.pop_front());
      end else begin
        check("idle_low4", sb4.o_tx_data, 1'b0);
      end
      if (sb4.o_packet_sent) pulse_cnt4++;
      prev_en4 = sb4.o_tx_clk_en;
    end else begin
      prev_en4 = 1'b0;
    end
  end

  // Advance to #1 after the edge that makes cyc equal c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Move to the sampling point (after the falling edge) of cycle E0+k.
  task automatic at(input int e0, input int k);
    goto(e0 + k - 1);
    @(negedge clk);
    #1;
  endtask

  // Post a packet: drive now, accept on the next rising edge. Expected bits
  // are queued only if the bench expects the slot to be free.
  task automatic post(input int sel, input logic [63:0] hdr, input logic [63:0] dat,
                      input bit hd, input bit exp_acc, input string tag, output int e0);
    if (sel == 0) begin
      check({tag, "_ready"}, sb.o_packet_ready, exp_acc);
      sb.i_header = hdr; sb.i_data = dat; sb.i_has_data = hd; sb.i_packet_enable = 1'b1;
    end else begin
      check({tag, "_ready"}, sb4.o_packet_ready, exp_acc);
      sb4.i_header = hdr; sb4.i_data = dat; sb4.i_has_data = hd; sb4.i_packet_enable = 1'b1;
    end
    @(posedge clk);
    #1;
    e0 = cyc;
    // Inputs are don't-care after acceptance; scramble them.
    if (sel == 0) begin
      sb.i_packet_enable = 1'b0; sb.i_header = ~hdr; sb.i_data = ~dat; sb.i_has_data = ~hd;
    end else begin
      sb4.i_packet_enable = 1'b0; sb4.i_header = ~hdr; sb4.i_data = ~dat; sb4.i_has_data = ~hd;
    end
    if (exp_acc) begin
      for (int i = 0; i < WORD_W; i++) begin
        if (sel == 0) exp_q.push_back(hdr[i]); else exp4_q.push_back(hdr[i]);
      end
      if (hd) begin
        for (int i = 0; i < WORD_W; i++) begin
          if (sel == 0) exp_q.push_back(dat[i]); else exp4_q.push_back(dat[i]);
        end
      end
    end
  endtask

  task automatic wait_ready4(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (sb4.o_packet_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, e0b, dummy;
    bit ok;

    n_cmp = 0; n_err = 0; cyc = 0;
    low_run = 0; last_gap = 0; prev_en = 0; prev_en4 = 0;
    pulse_cnt4 = 0; n_post4 = 0;
    rst_n = 1'b0;
    sb.i_packet_enable  = 1'b0; sb.i_header  = '0; sb.i_data  = '0; sb.i_has_data  = 1'b0;
    sb4.i_packet_enable = 1'b0; sb4.i_header = '0; sb4.i_data = '0; sb4.i_has_data = 1'b0;

    // ---- Reset values ------------------------------------------------------
    #3;
    check("rst_ready",   sb.o_packet_ready, 1'b1);
    check("rst_busy",    sb.o_busy,         1'b0);
    check("rst_tx_data", sb.o_tx_data,      1'b0);
    check("rst_clk_en",  sb.o_tx_clk_en,    1'b0);
    check("rst_sent",    sb.o_packet_sent,  1'b0);
    check("rst_ready4",  sb4.o_packet_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    check("post_rst_busy", sb.o_busy, 1'b0);

    // ---- Header only: 0xA5 --------------------------------------------------
    post(0, 64'h0000_0000_0000_00A5, 64'h0, 1'b0, 1'b1, "hdr_only", e0);
    at(e0, 1);   check("hdr_only_first_clk_en", sb.o_tx_clk_en, 1'b1);
    at(e0, 64);  check("hdr_only_last_clk_en",  sb.o_tx_clk_en, 1'b1);
    at(e0, 65);  check("hdr_only_gap_start",    sb.o_tx_clk_en, 1'b0);
    at(e0, 95);  check("hdr_only_sent_early",   sb.o_packet_sent, 1'b0);
    at(e0, 96);  check("hdr_only_sent",         sb.o_packet_sent, 1'b1);
                 check("hdr_only_busy_in_gap",  sb.o_busy,        1'b1);
    at(e0, 97);  check("hdr_only_sent_late",    sb.o_packet_sent, 1'b0);
                 check("hdr_only_idle_busy",    sb.o_busy,        1'b0);
                 check("hdr_only_drained",      exp_q.size(),     0);

    // ---- Header + data ------------------------------------------------------
    post(0, 64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, "hdr_data", e0);
    at(e0, 128); check("hdr_data_last_clk_en", sb.o_tx_clk_en,   1'b1);
    at(e0, 129); check("hdr_data_gap_start",   sb.o_tx_clk_en,   1'b0);
    at(e0, 159); check("hdr_data_sent_early",  sb.o_packet_sent, 1'b0);
    at(e0, 160); check("hdr_data_sent",        sb.o_packet_sent, 1'b1);
    at(e0, 161); check("hdr_data_sent_late",   sb.o_packet_sent, 1'b0);
                 check("hdr_data_idle_busy",   sb.o_busy,        1'b0);
                 check("hdr_data_drained",     exp_q.size(),     0);

    // ---- Holding slot: A, B held, C rejected --------------------------------
    post(0, 64'h0123_4567_89AB_CDEF, 64'h5555_AAAA_0F0F_F0F0, 1'b1, 1'b1, "hold_a", e0);
    goto(e0 + 9);
    post(0, 64'hCAFE_F00D_1357_9BDF, 64'h0, 1'b0, 1'b1, "hold_b", dummy);
    at(e0, 11);  check("hold_ready_low",  sb.o_packet_ready, 1'b0);
                 check("hold_busy",       sb.o_busy,         1'b1);
    goto(e0 + 19);
    post(0, 64'hBAD0_BAD0_BAD0_BAD0, 64'hBAD1_BAD1_BAD1_BAD1, 1'b1, 1'b0, "hold_c", dummy);
    at(e0, 160); check("hold_a_sent",      sb.o_packet_sent,  1'b1);
                 check("hold_ready_at_a",  sb.o_packet_ready, 1'b0);
    at(e0, 161); check("hold_b_starts",    sb.o_tx_clk_en,    1'b1);
                 check("hold_ready_rises", sb.o_packet_ready, 1'b1);
                 check("hold_gap_len",     last_gap,          GAP_A);
    at(e0, 256); check("hold_b_sent",      sb.o_packet_sent,  1'b1);
    at(e0, 257); check("hold_idle_busy",   sb.o_busy,         1'b0);
                 check("hold_drained",     exp_q.size(),      0);

    // ---- Gap boundary: B posted in A's last gap cycle -----------------------
    post(0, 64'h8000_0000_0000_0001, 64'h0, 1'b0, 1'b1, "gapb_a", e0);
    at(e0, 65);  check("gapb_gap_start", sb.o_tx_clk_en,   1'b0);
    at(e0, 96);  check("gapb_a_sent",    sb.o_packet_sent, 1'b1);
                 check("gapb_last_low",  sb.o_tx_clk_en,   1'b0);
    post(0, 64'h0F1E_2D3C_4B5A_6978, 64'h0, 1'b0, 1'b1, "gapb_b", e0b);
    check("gapb_accept_edge", e0b, e0 + 96);
    at(e0b, 1);  check("gapb_b_starts",  sb.o_tx_clk_en,   1'b1);
                 check("gapb_gap_len",   last_gap,         GAP_A);
    at(e0b, 96); check("gapb_b_sent",    sb.o_packet_sent, 1'b1);
    at(e0b, 97); check("gapb_idle_busy", sb.o_busy,        1'b0);
                 check("gapb_drained",   exp_q.size(),     0);

    // ---- Mid-packet reset ---------------------------------------------------
    post(0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b1, 1'b1, "mrst", e0);
    goto(e0 + 9);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_clk_en", sb.o_tx_clk_en,    1'b0);
    check("mrst_tx",     sb.o_tx_data,      1'b0);
    check("mrst_busy",   sb.o_busy,         1'b0);
    check("mrst_ready",  sb.o_packet_ready, 1'b1);
    check("mrst_sent",   sb.o_packet_sent,  1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    check("mrst_after_busy",   sb.o_busy,         1'b0);
    check("mrst_after_ready",  sb.o_packet_ready, 1'b1);
    at(cyc, 5);
    check("mrst_after_clk_en", sb.o_tx_clk_en,    1'b0);

    // ---- GAP_UI = 4: back-to-back header-only packets -----------------------
    for (int k = 1; k <= 5; k++) begin
      if (k > 2) begin
        wait_ready4(200, ok);
        check("gap4_ready_wait", ok, 1'b1);
      end
      post(1, 64'h1357_9BDF_2468_ACE0 ^ 64'(k * 37), 64'h0, 1'b0, 1'b1, "gap4", dummy);
      n_post4++;
    end
    for (int i = 0; i < 600 && pulse_cnt4 < n_post4; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("gap4_pulse_count", pulse_cnt4,     n_post4);
    check("gap4_burst_count", rise4_q.size(), n_post4);
    for (int i = 1; i < rise4_q.size(); i++)
      check("gap4_period", rise4_q[i] - rise4_q[i-1], WORD_W + GAP_B);
    check("gap4_drained",   exp4_q.size(), 0);
    check("gap4_idle_busy", sb4.o_busy,    1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_sb_tx_serializer

// File: doc/sb_tx_serializer.md
# sb_tx_serializer

Sideband transmit serializer for the UCIe PHY sideband path. It sits directly downstream of the sideband control FSM and its header/data framers. When the FSM asserts its packet enable, the block accepts a framed 64-bit header and an optional 64-bit data word. It shifts them out LSB-first on the single-bit sideband TX lane with a matching clock-enable, then enforces the mandatory low gap between packets. A one-deep holding register lets the FSM post the next packet while the current one is on the wire.

## Interface
Parameters:
- WORD_W, 64: bits per header or data word.
- GAP_UI, 32: number of idle-low UI after each packet; must be ≥ 2.

Ports:
- i_clk  in  1  sideband serial clock; one UI per cycle.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_packet_enable  in  1  packet-post strobe from the sideband FSM; qualified by o_packet_ready.
- i_header  in  WORD_W  framed header word.
- i_data  in  WORD_W  framed data word; ignored when i_has_data=0.
- i_has_data  in  1  when 1, the packet is header followed by data; when 0, header only.
- o_packet_ready  out  1  the holding slot is free (= ~hold_valid).
- o_tx_data  out  1  serial TX bit.
- o_tx_clk_en  out  1  forwarded sideband clock gate; high only during data UI.
- o_packet_sent  out  1  one-cycle pulse marking completion of a packet's gap.
- o_busy  out  1  state≠IDLE or hold_valid; drives the FSM's busy/timeout logic.

## Operation
- States: IDLE, SHIFT_HDR, SHIFT_DATA, GAP.
- A 7-bit UI counter counts words (0..WORD_W-1) and the gap (0..GAP_UI-1). It clears on every state entry.
- Accept: a packet is accepted on a clock edge where i_packet_enable=1 and o_packet_ready=1.
  - In IDLE, or in the last GAP cycle, an accepted packet loads the shift registers directly and the FSM enters SHIFT_HDR.
  - Otherwise the packet goes to the holding register and hold_valid is set.
- SHIFT_HDR: o_tx_data = hdr_sr[0]; hdr_sr shifts right each cycle. After WORD_W cycles:
  - has_data=1: go to SHIFT_DATA.
  - has_data=0: go to GAP.
- SHIFT_DATA: same as SHIFT_HDR on dat_sr; go to GAP after WORD_W cycles.
- GAP: o_tx_data=0, o_tx_clk_en=0 for GAP_UI cycles. o_packet_sent=1 during the final gap cycle. On exit:
  - hold_valid=1: move the held packet to the shifters, clear hold_valid, enter SHIFT_HDR.
  - Else, a packet accepted in the same cycle goes straight to SHIFT_HDR.
  - Else go to IDLE.
- o_tx_clk_en = 1 exactly in SHIFT_HDR and SHIFT_DATA. o_tx_data = 0 in IDLE and GAP.
- Priority: a held packet always beats a same-cycle new post. Ready is low while hold_valid=1, so the two never coexist.
- The accepted i_has_data is captured with its packet. Inputs are don't-care after acceptance.

## Timing
- Reset values: state=IDLE, all shift registers, hold registers and counter =0. Outputs: o_packet_ready=1, o_tx_data=0, o_tx_clk_en=0, o_packet_sent=0, o_busy=0.
- Acceptance at edge E0 means cycle E0+k (k=1..WORD_W) drives header bit k-1. Data bits follow immediately, with no bubble.
- Packet with data: 128 UI clk_en high, then GAP_UI UI low. o_packet_sent is high in cycle E0+128+GAP_UI.
- Header only: o_packet_sent is high in cycle E0+64+GAP_UI.
- Back-to-back throughput: the next header's bit 0 appears in the cycle immediately after the o_packet_sent cycle. There is never more or less than GAP_UI low UI.
- Mid-operation reset: all outputs go to their reset values immediately (asynchronously). Both the in-flight and the held packet are discarded.
- Inputs are sampled on the rising edge. All outputs are registered except o_packet_ready and o_busy, which are combinational from registers only.

## Test plan
- Reset check: assert i_rst_n=0 mid-SHIFT_HDR -> same cycle o_tx_clk_en=0, o_tx_data=0, o_busy=0, o_packet_ready=1. After release, state is IDLE.
- Header only: post header 0x0000_0000_0000_00A5, has_data=0 -> wire bits 1,0,1,0,0,1,0,1 then 56 zeros. 64 clk_en cycles, then 32 low. o_packet_sent is high exactly at E0+96.
- Header plus data: post header 0xDEAD_BEEF_0123_4567 with data 0xFFFF_FFFF_FFFF_FFFF -> 64 header bits LSB-first, then 64 ones. 128 clk_en cycles, pulse at E0+160.
- Holding slot: post packet A, then post B at E0+10 -> o_packet_ready drops at E0+11. Post C at E0+20 is ignored (ready=0). B's bit 0 appears the cycle after A's o_packet_sent pulse, and ready rises the same cycle.
- Gap boundary: post packet B exactly in A's last GAP cycle with hold empty -> B starts the next cycle. The gap is exactly 32 low UI.
- GAP_UI=4 instance: back-to-back header-only packets -> the period is exactly 68 cycles and the pulse count equals the packet count.
